// File: rtl/coeff_stream_reader_pkg.sv
// Shared ECG datapath definitions: bus widths, reader FSM states and
// the circular address step used by both the read and write address units.
package ecg_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Next address in a circular buffer of 'depth' words.
  // Wraps at depth-1 even when depth is not a power of two.
  function automatic int unsigned next_addr(
    input int unsigned addr,
    input int unsigned depth
  );
    return (addr + 32'd1 >= depth) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/coeff_stream_reader_if.sv
// RAM read port plus output stream of the coefficient reader.
// master: reader side (drives rd_en/rd_addr/dout/dout_valid); slave: RAM + sink.
interface coeff_stream_reader_if #(
  parameter int DATA_W = ecg_pkg::DATA_W,
  parameter int ADDR_W = ecg_pkg::ADDR_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/coeff_stream_reader_skid_fifo2.sv
// Two-entry FIFO absorbing the RAM read latency.
// Ports: clk, rst_n, i_push/i_push_data, i_pop, o_count, o_head.
module skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/coeff_stream_reader.sv
// Reads a block of len words from a circular RAM starting at base_addr
// and streams them out. Ports: clk, rst_n, bus (RAM port + stream), start/base_addr/len, busy, done.
module coeff_stream_reader
  import ecg_pkg::*;
#(
  parameter int DATA_W = ecg_pkg::DATA_W,
  parameter int ADDR_W = ecg_pkg::ADDR_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  coeff_stream_reader_if.master bus,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic              r_inflight;

  logic              w_start_ok;
  logic              w_issue;
  logic              w_room;
  logic              w_pop;
  logic              w_valid;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_head;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_valid    = (w_count != 2'd0);
  assign w_pop      = w_valid && bus.dout_ready;

  // A pop in this cycle frees a slot for the word that lands two
  // cycles later, which is what keeps back-to-back throughput.
  assign w_room = ((w_count + {1'b0, r_inflight}) < 2'd2) || w_pop;

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy    = 1'b1;
        w_issue = (r_issued < r_len) && w_room;
        if (w_issue && (r_issued + 1'b1 == r_len)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Finishes in the cycle of the final handshake.
        if (!r_inflight &&
            (w_count == 2'd0 || (w_count == 2'd1 && w_pop))) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_start_ok) begin
        r_addr   <= base_addr;
        r_len    <= len;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= ADDR_W'(next_addr(32'(r_addr), DEPTH));
        r_issued <= r_issued + 1'b1;
      end
    end
  end

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (bus.rd_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign bus.rd_en      = w_issue;
  assign bus.rd_addr    = r_addr;
  assign bus.dout_valid = w_valid;
  assign bus.dout       = w_valid ? w_head : '0;

endmodule
